mcu_cmd_seq: RTL and testbench
==============================

Name: mcu_cmd_seq

Overview:
- FPGA-internal initiator for the MCU command/parameter strobe interface consumed by the command interpreter.
- Frames are pushed in as a byte stream with end-of-frame markers and buffered in a FIFO.
- Emits cmd_ready/param_ready strobes with SPI-equivalent byte/bit counters and spacing.
- Captures the interpreter's return byte once per transferred byte.
- Used for autonomous config (boot-time mask/mapper/feature programming) and as a bench-replaceable SPI front end.

Parameters:
FIFO_DEPTH_LOG2, 4, frame byte FIFO depth = 2^FIFO_DEPTH_LOG2 entries of {last,data}
BIT_CYCLES, 2, clk cycles per emulated SPI bit; byte period = 8*BIT_CYCLES + 1 (min 1)
TIMEOUT_CYCLES, 1024, underrun timeout (only with MCU_CMD_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  8  frame byte
in_last  in  1  marks final byte of frame
in_valid  in  1  push request
in_ready  out  1  FIFO not full; push occurs when in_valid & in_ready
cmd_ready  out  1  one-cycle strobe, command byte valid
param_ready  out  1  one-cycle strobe, parameter byte valid
cmd_data  out  8  current command byte, held until next command strobe
param_data  out  8  current parameter byte, held until next param strobe
spi_byte_cnt  out  32  1 for command byte, 2.. for params, 0 between frames
spi_bit_cnt  out  3  emulated bit position within byte
spi_data_in  in  8  return byte from interpreter
rsp_data  out  8  captured return byte
rsp_valid  out  1  one-cycle strobe, rsp_data updated
busy  out  1  high from first pop until frame_done
frame_done  out  1  one-cycle pulse at frame end
frame_err  out  1  one-cycle pulse on timeout; constant 0 when feature absent

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO flushed, all outputs 0 (cmd_data=param_data=rsp_data=8'h00, counters 0), in_ready=1 after release. Reset mid-frame drops frame silently, no frame_done.
- FIFO: synchronous, first-word-fall-through, registered full/empty; simultaneous push+pop when full is NOT allowed (in_ready=0 blocks push); when empty, push and pop in same cycle cannot occur (pop sees data next cycle).
- States: IDLE, STROBE, SHIFT, HOLD, DONE.
- IDLE: spi_byte_cnt=0, spi_bit_cnt=0. FIFO non-empty -> pop, go STROBE.
- STROBE (1 cycle): spi_byte_cnt += 1. If previous value 0: cmd_ready=1, cmd_data=byte. Else: param_ready=1, param_data=byte, cmd_data unchanged. Data and strobe change in the same cycle (registered). Latch last flag. -> SHIFT, bit_cnt=0, subcnt=0.
- SHIFT: subcnt counts 0..BIT_CYCLES-1; on wrap bit_cnt increments. At bit_cnt=7 & subcnt=BIT_CYCLES-1: rsp_data<=spi_data_in, rsp_valid=1 next cycle. Then: last latched -> DONE; FIFO non-empty -> pop, STROBE; else -> HOLD.
- Strobe spacing with continuous data: exactly 8*BIT_CYCLES+1 cycles.
- HOLD: bit_cnt stays 7, no strobes, busy=1; FIFO non-empty -> pop, STROBE.
- DONE (1 cycle): frame_done=1, spi_byte_cnt<=0, busy<=0, -> IDLE.
- A byte with in_last=1 as the sole byte is a valid command-only frame.
- spi_byte_cnt wraps modulo 2^32 (not reachable in practice; no saturation).

Optional Feature:
- Macro: MCU_CMD_SEQ_TIMEOUT_EN.
- Defined: HOLD counts cycles; reaching TIMEOUT_CYCLES -> frame_err=1 and frame_done=1 in the same cycle, byte_cnt=0, -> IDLE. The frame's remaining bytes arriving later start a new frame as a command byte. Counter clears on each STROBE.
- Undefined: HOLD waits indefinitely; frame_err tied 0.

Test Plan:
- BIT_CYCLES=2, push {0xF0,last}, spi_data_in=0xA5 -> cmd_ready single pulse, cmd_data=0xF0, byte_cnt=1; rsp_valid with rsp_data=0xA5; frame_done next cycle; byte_cnt=0.
- Push {0x10,0x12,0x34,0x56(last)} -> one cmd_ready then 3 param_ready 17 cycles apart. byte_cnt=2,3,4, param_data 0x12,0x34,0x56, cmd_data stays 0x10, 4 rsp_valid pulses.
- 20 back-to-back pushes without in_last, then last -> in_ready drops at 16 occupancy; all 21 bytes emitted in order, none lost or duplicated.
- Push 0xE2, idle 100 cycles, push 0x00 last -> HOLD with bit_cnt=7, no strobes; then param_ready, byte_cnt=2, param_data=0x00.
- Assert rst_n=0 during SHIFT of byte 2 -> all outputs 0 immediately, no frame_done. Next frame starts with cmd_ready and byte_cnt=1.
- With MCU_CMD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, push 0xED, stall -> frame_err and frame_done pulse 64 cycles into HOLD; FSM returns to IDLE.

Source files
------------

// File: rtl/mcu_cmd_seq.sv
// mcu_cmd_seq: FPGA-internal initiator for the MCU command/parameter strobe
// interface. Frame bytes are buffered in a first-word-fall-through FIFO and
// replayed as cmd_ready/param_ready strobes with SPI-equivalent byte and bit
// counters. One return byte is captured per transferred byte.
// Optional feature macro: MCU_CMD_SEQ_TIMEOUT_EN (HOLD underrun timeout that
// aborts the frame with frame_err).
module mcu_cmd_seq #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BIT_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        cmd_ready,
    output logic        param_ready,
    output logic [7:0]  cmd_data,
    output logic [7:0]  param_data,
    output logic [31:0] spi_byte_cnt,
    output logic [2:0]  spi_bit_cnt,
    input  logic [7:0]  spi_data_in,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int SUB_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIT_CYCLES - 1);

    // Reject parameter values that make the byte period or FIFO meaningless.
    if (FIFO_DEPTH_LOG2 < 1 || BIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mcu_cmd_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Frame byte FIFO: {last,data} entries, registered empty and ready.
    // ------------------------------------------------------------------
    logic [8:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       empty_q, empty_d;
    logic                       in_ready_q, in_ready_d;
    logic                       push;
    logic                       pop;
    logic [8:0]                 head;

    assign push = in_valid & in_ready_q;
    assign head = mem_q[rd_ptr_q];

    // Storage array write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_last, in_data};
        end
    end

    // Next pointers, occupancy and the registered empty/ready flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d    = (count_d == CW'(0));
        in_ready_d = (count_d != CW'(DEPTH));
    end

    // FIFO control registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Strobe sequencer
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [31:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [SUB_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic               last_q, last_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               param_ready_q, param_ready_d;
    logic [7:0]         cmd_data_q, cmd_data_d;
    logic [7:0]         param_data_q, param_data_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               start_byte;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic               frame_err_q, frame_err_d;
`endif

    // Next-state and registered-output logic; every pop funnels through start_byte.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sub_cnt_d     = sub_cnt_q;
        last_d        = last_q;
        cmd_data_d    = cmd_data_q;
        param_data_d  = param_data_q;
        rsp_data_d    = rsp_data_q;
        busy_d        = busy_q;
        cmd_ready_d   = 1'b0;
        param_ready_d = 1'b0;
        rsp_valid_d   = 1'b0;
        frame_done_d  = 1'b0;
        start_byte    = 1'b0;
        pop           = 1'b0;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        frame_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                sub_cnt_d = '0;
                if (!empty_q) begin
                    start_byte = 1'b1;
                end
            end
            ST_STROBE: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = 3'd0;
                sub_cnt_d = '0;
            end
            ST_SHIFT: begin
                if (sub_cnt_q != SUB_LAST) begin
                    sub_cnt_d = sub_cnt_q + SUB_W'(1);
                end else if (bit_cnt_q != 3'd7) begin
                    sub_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    rsp_data_d  = spi_data_in;
                    rsp_valid_d = 1'b1;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (!empty_q) begin
                        start_byte = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end
                end
            end
            ST_HOLD: begin
                if (!empty_q) begin
                    start_byte = 1'b1;
                end else begin
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
                    if (hold_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        frame_err_d  = 1'b1;
                        frame_done_d = 1'b1;
                        byte_cnt_d   = 32'd0;
                        busy_d       = 1'b0;
                        bit_cnt_d    = 3'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + TO_W'(1);
                    end
`endif
                end
            end
            ST_DONE: begin
                frame_done_d = 1'b1;
                byte_cnt_d   = 32'd0;
                busy_d       = 1'b0;
                bit_cnt_d    = 3'd0;
                sub_cnt_d    = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_byte) begin
            pop        = 1'b1;
            byte_cnt_d = byte_cnt_q + 32'd1;
            if (byte_cnt_q == 32'd0) begin
                cmd_ready_d = 1'b1;
                cmd_data_d  = head[7:0];
            end else begin
                param_ready_d = 1'b1;
                param_data_d  = head[7:0];
            end
            last_d    = head[8];
            bit_cnt_d = 3'd0;
            sub_cnt_d = '0;
            busy_d    = 1'b1;
            state_d   = ST_STROBE;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
        end
    end

    // Sequencer state and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= 32'd0;
            bit_cnt_q     <= 3'd0;
            sub_cnt_q     <= '0;
            last_q        <= 1'b0;
            cmd_ready_q   <= 1'b0;
            param_ready_q <= 1'b0;
            cmd_data_q    <= 8'h00;
            param_data_q  <= 8'h00;
            rsp_data_q    <= 8'h00;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
            hold_cnt_q    <= '0;
            frame_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sub_cnt_q     <= sub_cnt_d;
            last_q        <= last_d;
            cmd_ready_q   <= cmd_ready_d;
            param_ready_q <= param_ready_d;
            cmd_data_q    <= cmd_data_d;
            param_data_q  <= param_data_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
            frame_err_q   <= frame_err_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign cmd_ready    = cmd_ready_q;
    assign param_ready  = param_ready_q;
    assign cmd_data     = cmd_data_q;
    assign param_data   = param_data_q;
    assign spi_byte_cnt = byte_cnt_q;
    assign spi_bit_cnt  = bit_cnt_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
    assign frame_err    = frame_err_q;
`else
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_cmd_seq.sv
// Testbench for mcu_cmd_seq: a phase-based reference model of the strobe
// timing is compared against every output each cycle, and directed frames
// are cross-checked against hand-computed constants.
module tb_mcu_cmd_seq;

    localparam int BC = 2;
    localparam int TO = 64;
    localparam int BYTE_SPAN = 8 * BC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        cmd_ready;
    logic        param_ready;
    logic [7:0]  cmd_data;
    logic [7:0]  param_data;
    logic [31:0] spi_byte_cnt;
    logic [2:0]  spi_bit_cnt;
    logic [7:0]  spi_data_in;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    mcu_cmd_seq #(
        .FIFO_DEPTH_LOG2(4),
        .BIT_CYCLES(BC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_last(in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cmd_ready(cmd_ready),
        .param_ready(param_ready),
        .cmd_data(cmd_data),
        .param_data(param_data),
        .spi_byte_cnt(spi_byte_cnt),
        .spi_bit_cnt(spi_bit_cnt),
        .spi_data_in(spi_data_in),
        .rsp_data(rsp_data),
        .rsp_valid(rsp_valid),
        .busy(busy),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Count one comparison and report it when the values differ.
    task checkOutput(input string name, input logic [65:0] got, input logic [65:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // An expired wait counts as a failed comparison.
    task expired(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s wait expired got=timeout want=event (cycle %0d)", name, cycle);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a byte is a window of 8*BC+1 cycles counted from
    // its strobe; the bit index is derived from the cycle offset.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_BYTE, M_HOLD, M_END} mode_t;

    logic [8:0]  mq[$];
    mode_t       m_mode = M_IDLE;
    int          m_phase = 0;
    int          m_hold = 0;
    logic        m_last = 0;
    logic        m_in_ready = 0;
    logic        m_cmd_ready = 0;
    logic        m_param_ready = 0;
    logic [7:0]  m_cmd_data = 0;
    logic [7:0]  m_param_data = 0;
    logic [31:0] m_byte_cnt = 0;
    logic [2:0]  m_bit = 0;
    logic [7:0]  m_rsp_data = 0;
    logic        m_rsp_valid = 0;
    logic        m_busy = 0;
    logic        m_frame_done = 0;
    logic        m_frame_err = 0;

    task model_start;
        if (m_byte_cnt == 32'd0) begin
            m_cmd_ready <= 1'b1;
            m_cmd_data  <= mq[0][7:0];
        end else begin
            m_param_ready <= 1'b1;
            m_param_data  <= mq[0][7:0];
        end
        m_last     <= mq[0][8];
        m_byte_cnt <= m_byte_cnt + 32'd1;
        m_phase    <= 0;
        m_bit      <= 3'd0;
        m_busy     <= 1'b1;
        m_mode     <= M_BYTE;
        m_hold     <= 0;
        mq.delete(0);
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            mq.delete();
            m_mode        <= M_IDLE;
            m_phase       <= 0;
            m_hold        <= 0;
            m_last        <= 1'b0;
            m_in_ready    <= 1'b0;
            m_cmd_ready   <= 1'b0;
            m_param_ready <= 1'b0;
            m_cmd_data    <= 8'h00;
            m_param_data  <= 8'h00;
            m_byte_cnt    <= 32'd0;
            m_bit         <= 3'd0;
            m_rsp_data    <= 8'h00;
            m_rsp_valid   <= 1'b0;
            m_busy        <= 1'b0;
            m_frame_done  <= 1'b0;
            m_frame_err   <= 1'b0;
        end else begin
            m_cmd_ready   <= 1'b0;
            m_param_ready <= 1'b0;
            m_rsp_valid   <= 1'b0;
            m_frame_done  <= 1'b0;
            m_frame_err   <= 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (mq.size() > 0) model_start();
                end
                M_BYTE: begin
                    if (m_phase < BYTE_SPAN) begin
                        m_phase <= m_phase + 1;
                        m_bit   <= 3'(m_phase / BC);
                    end else begin
                        m_rsp_data  <= spi_data_in;
                        m_rsp_valid <= 1'b1;
                        if (m_last) m_mode <= M_END;
                        else if (mq.size() > 0) model_start();
                        else begin
                            m_mode <= M_HOLD;
                            m_hold <= 0;
                        end
                    end
                end
                M_HOLD: begin
                    if (mq.size() > 0) model_start();
`ifdef MCU_CMD_SEQ_TIMEOUT_EN
                    else if (m_hold + 1 == TO) begin
                        m_frame_err  <= 1'b1;
                        m_frame_done <= 1'b1;
                        m_byte_cnt   <= 32'd0;
                        m_busy       <= 1'b0;
                        m_bit        <= 3'd0;
                        m_mode       <= M_IDLE;
                    end else m_hold <= m_hold + 1;
`endif
                end
                M_END: begin
                    m_frame_done <= 1'b1;
                    m_byte_cnt   <= 32'd0;
                    m_busy       <= 1'b0;
                    m_bit        <= 3'd0;
                    m_mode       <= M_IDLE;
                end
                default: m_mode <= M_IDLE;
            endcase
            if (in_valid && m_in_ready) mq.push_back({in_last, in_data});
            m_in_ready <= (mq.size() != 16);
        end
    end

    logic [65:0] dut_vec;
    logic [65:0] model_vec;
    assign dut_vec = {in_ready, cmd_ready, param_ready, cmd_data, param_data, spi_byte_cnt,
                      spi_bit_cnt, rsp_data, rsp_valid, busy, frame_done, frame_err};
    assign model_vec = {m_in_ready, m_cmd_ready, m_param_ready, m_cmd_data, m_param_data, m_byte_cnt,
                        m_bit, m_rsp_data, m_rsp_valid, m_busy, m_frame_done, m_frame_err};

    // Every cycle, all outputs must agree with the model.
    always @(negedge clk) checkOutput("cycle_model", dut_vec, model_vec);

    // ------------------------------------------------------------------
    // Event logs for the hand-computed checks.
    // ------------------------------------------------------------------
    logic [7:0]  cmd_log[$];
    logic [31:0] cmd_cnt_log[$];
    logic [7:0]  param_log[$];
    logic [31:0] param_cnt_log[$];
    int          param_cyc_log[$];
    logic [7:0]  rsp_log[$];
    int          cmd_cyc = 0;
    int          rsp_cyc = 0;
    int          done_cyc = 0;
    int          err_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic        saw_not_ready = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_ready) begin
                cmd_log.push_back(cmd_data);
                cmd_cnt_log.push_back(spi_byte_cnt);
                cmd_cyc <= cycle;
            end
            if (param_ready) begin
                param_log.push_back(param_data);
                param_cnt_log.push_back(spi_byte_cnt);
                param_cyc_log.push_back(cycle);
            end
            if (rsp_valid) begin
                rsp_log.push_back(rsp_data);
                rsp_cyc <= cycle;
            end
            if (frame_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cycle;
            end
            if (frame_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cycle;
            end
            if (!in_ready) saw_not_ready <= 1'b1;
        end
    end

    task clear_logs;
        cmd_log.delete();
        cmd_cnt_log.delete();
        param_log.delete();
        param_cnt_log.delete();
        param_cyc_log.delete();
        rsp_log.delete();
    endtask

    // Offer one byte at a negedge and hold it until accepted; leaves in_valid high.
    task applyStimulus(input logic [7:0] d, input logic l);
        logic ok;
        int   guard;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok       = 1'b0;
        guard    = 0;
        while (!ok) begin
            ok = in_ready;
            @(negedge clk);
            guard++;
            if (!ok && guard > 2000) begin
                expired("push_accept");
                ok = 1'b1;
            end
        end
    endtask

    task stop_push;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task wait_done(input string name, input int limit);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start) expired(name);
    endtask

    logic [7:0] vec2 [4];
    int base_done;

    initial begin
        vec2 = '{8'h10, 8'h12, 8'h34, 8'h56};
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        spi_data_in = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_byte_cnt", spi_byte_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_in_ready", in_ready, 1);
        checkOutput("post_reset_busy", busy, 0);

        // Test 1: command-only frame
        $display("[TB] command-only frame");
        clear_logs();
        spi_data_in = 8'hA5;
        applyStimulus(8'hF0, 1'b1);
        stop_push();
        wait_done("t1_done", 100);
        @(negedge clk);
        checkOutput("t1_cmd_count", cmd_log.size(), 1);
        checkOutput("t1_cmd_data", cmd_log[0], 8'hF0);
        checkOutput("t1_cmd_byte_cnt", cmd_cnt_log[0], 1);
        checkOutput("t1_rsp_count", rsp_log.size(), 1);
        checkOutput("t1_rsp_data", rsp_log[0], 8'hA5);
        checkOutput("t1_rsp_latency", rsp_cyc - cmd_cyc, 17);
        checkOutput("t1_done_latency", done_cyc - cmd_cyc, 18);
        checkOutput("t1_byte_cnt_idle", spi_byte_cnt, 0);
        checkOutput("t1_param_count", param_log.size(), 0);

        // Test 2: command plus three parameters
        $display("[TB] four-byte frame");
        clear_logs();
        spi_data_in = 8'h3C;
        for (int i = 0; i < 4; i++) applyStimulus(vec2[i], (i == 3));
        stop_push();
        wait_done("t2_done", 200);
        @(negedge clk);
        checkOutput("t2_cmd_count", cmd_log.size(), 1);
        checkOutput("t2_param_count", param_log.size(), 3);
        if (param_log.size() == 3) begin
            checkOutput("t2_param0", param_log[0], 8'h12);
            checkOutput("t2_param1", param_log[1], 8'h34);
            checkOutput("t2_param2", param_log[2], 8'h56);
            checkOutput("t2_cnt0", param_cnt_log[0], 2);
            checkOutput("t2_cnt1", param_cnt_log[1], 3);
            checkOutput("t2_cnt2", param_cnt_log[2], 4);
            checkOutput("t2_gap0", param_cyc_log[0] - cmd_cyc, 17);
            checkOutput("t2_gap1", param_cyc_log[1] - param_cyc_log[0], 17);
            checkOutput("t2_gap2", param_cyc_log[2] - param_cyc_log[1], 17);
        end
        checkOutput("t2_rsp_count", rsp_log.size(), 4);
        checkOutput("t2_cmd_held", cmd_data, 8'h10);

        // Test 3: 21-byte frame overflowing the FIFO
        $display("[TB] long frame with back-pressure");
        clear_logs();
        saw_not_ready = 1'b0;
        spi_data_in = 8'h5A;
        for (int i = 0; i < 21; i++) applyStimulus(8'(8'h20 + i), (i == 20));
        stop_push();
        wait_done("t3_done", 1000);
        @(negedge clk);
        checkOutput("t3_backpressure", saw_not_ready, 1);
        checkOutput("t3_byte_total", cmd_log.size() + param_log.size(), 21);
        if (cmd_log.size() == 1 && param_log.size() == 20) begin
            checkOutput("t3_cmd", cmd_log[0], 8'h20);
            for (int i = 0; i < 20; i++) checkOutput("t3_param_order", param_log[i], 8'(8'h21 + i));
        end
        checkOutput("t3_rsp_count", rsp_log.size(), 21);

        // Test 4: underrun holds with bit_cnt at 7
        $display("[TB] underrun hold");
        clear_logs();
        applyStimulus(8'hE2, 1'b0);
        stop_push();
        repeat (100) @(negedge clk);
        checkOutput("t4_hold_bit_cnt", spi_bit_cnt, 7);
        checkOutput("t4_hold_busy", busy, 1);
        checkOutput("t4_hold_no_param", param_log.size(), 0);
        checkOutput("t4_hold_cmd_count", cmd_log.size(), 1);
`ifndef MCU_CMD_SEQ_TIMEOUT_EN
        applyStimulus(8'h00, 1'b1);
        stop_push();
        wait_done("t4_done", 100);
        @(negedge clk);
        checkOutput("t4_param_count", param_log.size(), 1);
        if (param_log.size() == 1) begin
            checkOutput("t4_param_data", param_log[0], 8'h00);
            checkOutput("t4_param_cnt", param_cnt_log[0], 2);
        end
`else
        repeat (20) @(negedge clk);
`endif

        // Test 5: reset during the second byte
        $display("[TB] reset mid-frame");
        clear_logs();
        base_done = done_cnt;
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hB2, 1'b0);
        applyStimulus(8'hC3, 1'b0);
        stop_push();
        for (int n = 0; n < 100 && param_log.size() == 0; n++) @(negedge clk);
        if (param_log.size() == 0) expired("t5_second_byte");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_byte_cnt", spi_byte_cnt, 0);
        checkOutput("t5_rst_cmd_data", cmd_data, 0);
        checkOutput("t5_rst_param_data", param_data, 0);
        checkOutput("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t5_no_frame_done", done_cnt - base_done, 0);
        applyStimulus(8'hD4, 1'b1);
        stop_push();
        wait_done("t5_done", 100);
        @(negedge clk);
        checkOutput("t5_cmd_count", cmd_log.size(), 2);
        if (cmd_log.size() == 2) begin
            checkOutput("t5_new_cmd", cmd_log[1], 8'hD4);
            checkOutput("t5_new_cnt", cmd_cnt_log[1], 1);
        end
        checkOutput("t5_param_count", param_log.size(), 1);

`ifdef MCU_CMD_SEQ_TIMEOUT_EN
        // Test 6: HOLD timeout aborts the frame
        $display("[TB] hold timeout");
        clear_logs();
        base_done = err_cnt;
        applyStimulus(8'hED, 1'b0);
        stop_push();
        for (int n = 0; n < 300 && err_cnt == base_done; n++) @(negedge clk);
        if (err_cnt == base_done) expired("t6_frame_err");
        @(negedge clk);
        checkOutput("t6_err_latency", err_cyc - cmd_cyc, 81);
        checkOutput("t6_done_with_err", done_cyc, err_cyc);
        checkOutput("t6_byte_cnt", spi_byte_cnt, 0);
        checkOutput("t6_busy", busy, 0);
        applyStimulus(8'h01, 1'b1);
        stop_push();
        wait_done("t6_done", 100);
        @(negedge clk);
        checkOutput("t6_cmd_count", cmd_log.size(), 2);
        if (cmd_log.size() == 2) begin
            checkOutput("t6_restart_cmd", cmd_log[1], 8'h01);
            checkOutput("t6_restart_cnt", cmd_cnt_log[1], 1);
        end
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound the whole run in case the design stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
